// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, data width and
// the baud divider computation.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam int UART_DATA_BITS = 8;

  // Integer truncation: the bit period is rounded down to whole clock cycles.
  function automatic int calc_baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous-reset circular byte buffer with registered count/full/empty flags.
// Writes while full and reads while empty are ignored.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int INDEX_SIZE = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [UART_DATA_BITS-1:0] din,
  output logic [UART_DATA_BITS-1:0] dout,
  output logic [INDEX_SIZE:0]       count,
  output logic                      full,
  output logic                      empty
);

  localparam logic [INDEX_SIZE:0]   FULL_COUNT = (INDEX_SIZE + 1)'(DEPTH);
  localparam logic [INDEX_SIZE:0]   CNT_ONE    = (INDEX_SIZE + 1)'(1);
  localparam logic [INDEX_SIZE-1:0] PTR_ONE    = INDEX_SIZE'(1);

  if (DEPTH != (1 << INDEX_SIZE)) begin : g_depth_check
    $error("uart_byte_fifo: DEPTH must equal 2**INDEX_SIZE");
  end

  logic [UART_DATA_BITS-1:0] mem [DEPTH];
  logic [INDEX_SIZE-1:0]     wr_ptr_reg;
  logic [INDEX_SIZE-1:0]     rd_ptr_reg;
  logic [INDEX_SIZE:0]       count_reg;
  logic [INDEX_SIZE:0]       count_next;
  logic                      full_reg;
  logic                      empty_reg;
  logic                      push_ok;
  logic                      pop_ok;

  // Acceptance is judged on pre-edge flags, so a push while full is lost even
  // if a pop frees a slot on the same edge.
  assign push_ok = push && !full_reg;
  assign pop_ok  = pop && !empty_reg;

  always_comb begin
    count_next = count_reg;
    if (push_ok && !pop_ok) begin
      count_next = count_reg + CNT_ONE;
    end else if (pop_ok && !push_ok) begin
      count_next = count_reg - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      count_reg <= count_next;
      full_reg  <= (count_next == FULL_COUNT);
      empty_reg <= (count_next == '0);
    end
  end

  assign dout  = mem[rd_ptr_reg];
  assign count = count_reg;
  assign full  = full_reg;
  assign empty = empty_reg;

endmodule

// File: rtl/uart_tx_unit.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a start/data/stop serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_unit
  import uart_pkg::*;
#(
  parameter int SYS_CLK_FREQ    = 100000000,
  parameter int UART_BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH      = 16,
  parameter int FIFO_INDEX_SIZE = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_enabled,
  input  logic [UART_DATA_BITS-1:0] wr_data,
  output logic                      fifo_full,
  output logic [FIFO_INDEX_SIZE:0]  fifo_count,
  output logic                      overflow,
  output logic                      tx_busy,
  output logic                      Tx
);

  localparam int BAUD_DIV = calc_baud_div(SYS_CLK_FREQ, UART_BAUD_RATE);
  localparam int BAUD_W   = (BAUD_DIV < 2) ? 1 : $clog2(BAUD_DIV);
  localparam int BIT_W    = $clog2(UART_DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

  if (BAUD_DIV < 2) begin : g_baud_check
    $error("uart_tx_unit: SYS_CLK_FREQ / UART_BAUD_RATE must be at least 2");
  end

  uart_state_t               state_reg;
  logic [BAUD_W-1:0]         baud_cnt_reg;
  logic [BIT_W-1:0]          bit_idx_reg;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic                      tx_reg;
  logic                      busy_reg;
  logic                      overflow_reg;
`ifdef UART_TX_PARITY_EN
  logic                      parity_reg;
`endif

  logic                      baud_end;
  logic                      fifo_pop;
  logic                      fifo_empty;
  logic                      fifo_full_w;
  logic [UART_DATA_BITS-1:0] fifo_dout;
  logic                      tx_next;

  uart_byte_fifo #(
    .DEPTH      (FIFO_DEPTH),
    .INDEX_SIZE (FIFO_INDEX_SIZE)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_enabled),
    .pop   (fifo_pop),
    .din   (wr_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full_w),
    .empty (fifo_empty)
  );

  assign baud_end = (baud_cnt_reg == BAUD_LAST);

  // Pop from IDLE, or at the end of STOP so the next frame follows with no gap.
  assign fifo_pop = !fifo_empty &&
                    ((state_reg == ST_IDLE) || ((state_reg == ST_STOP) && baud_end));

  // Line level is derived from the current state and registered, so Tx
  // trails the state by one cycle; tx_busy is registered the same way.
  always_comb begin
    tx_next = 1'b1;
    case (state_reg)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shift_reg[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_next = parity_reg;
`endif
      default:   tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      overflow_reg <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      if (wr_enabled && fifo_full_w) overflow_reg <= 1'b1;
      tx_reg   <= tx_next;
      busy_reg <= (state_reg != ST_IDLE);

      case (state_reg)
        ST_IDLE: begin
          if (!fifo_empty) begin
            shift_reg    <= fifo_dout;
`ifdef UART_TX_PARITY_EN
            parity_reg   <= ^fifo_dout;
`endif
            baud_cnt_reg <= '0;
            state_reg    <= ST_START;
          end
        end
        ST_START: begin
          if (baud_end) begin
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            state_reg    <= ST_DATA;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + BAUD_ONE;
          end
        end
        ST_DATA: begin
          if (baud_end) begin
            baud_cnt_reg <= '0;
            shift_reg    <= shift_reg >> 1;
            bit_idx_reg  <= bit_idx_reg + BIT_ONE;
            if (bit_idx_reg == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_reg <= ST_PARITY;
`else
              state_reg <= ST_STOP;
`endif
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + BAUD_ONE;
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (baud_end) begin
            baud_cnt_reg <= '0;
            state_reg    <= ST_STOP;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + BAUD_ONE;
          end
        end
`endif
        ST_STOP: begin
          if (baud_end) begin
            baud_cnt_reg <= '0;
            if (!fifo_empty) begin
              shift_reg  <= fifo_dout;
`ifdef UART_TX_PARITY_EN
              parity_reg <= ^fifo_dout;
`endif
              state_reg  <= ST_START;
            end else begin
              state_reg  <= ST_IDLE;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + BAUD_ONE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign fifo_full = fifo_full_w;
  assign overflow  = overflow_reg;
  assign tx_busy   = busy_reg;
  assign Tx        = tx_reg;

endmodule
